// File: rtl/ram_sdp_init.sv
// Simple dual-port RAM with one write port and one registered read port.
// It adds per-lane write masking, a read-valid strobe and a selectable
// read-during-write mode. After every reset an init sequencer fills all
// entries with INIT_VAL before the ports are accepted.
module ram_sdp_init #(
  parameter int               WIDTH    = 16,
  parameter int               ADDR_W   = 4,
  parameter int               LANE_W   = 8,
  parameter int               RDW_MODE = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      init_busy,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [WIDTH/LANE_W-1:0]   wr_mask,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LANES = WIDTH / LANE_W;

  // A word that does not split into whole lanes has no sensible mask meaning.
  if (WIDTH % LANE_W != 0) begin : g_bad_width
    $error("ram_sdp_init: WIDTH must be a multiple of LANE_W");
  end

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_init_ptr;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [WIDTH-1:0]    r_rd_data;
  logic                r_rd_valid;
  logic                w_init_we;
  logic                w_run;
  logic [WIDTH-1:0]    w_rd_word;

  // The sequencer only writes on edges where reset is not asserted, so the
  // reset edge itself leaves memory untouched.
  assign w_init_we = rst_n && (r_state == ST_INIT);
  assign w_run     = rst_n && (r_state == ST_RUN);

  // State register; reset always restarts the init sweep.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_next;
  end

  // Next-state: leave INIT on the edge that writes the last entry.
  always_comb begin
    // NOTE: default first so no path leaves w_state_next unassigned (no latch).
    w_state_next = r_state;
    unique case (r_state)
      ST_INIT: if (r_init_ptr == ADDR_W'(DEPTH - 1)) w_state_next = ST_RUN;
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_INIT;
    endcase
  end

  // Init pointer walks 0..DEPTH-1 and wraps back to 0 as INIT finishes.
  always_ff @(posedge clk) begin
    if (!rst_n)         r_init_ptr <= '0;
    else if (w_init_we) r_init_ptr <= r_init_ptr + 1'b1;
  end

  // Storage: full-word init writes, otherwise lane-masked user writes.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; clearing is done by the init
    // sequencer, which keeps the array mappable to block RAM.
    if (w_init_we) begin
      r_mem[r_init_ptr] <= INIT_VAL;
    end else if (w_run && wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_mask[l]) r_mem[wr_addr][l*LANE_W +: LANE_W] <= wr_data[l*LANE_W +: LANE_W];
      end
    end
  end

  // Read word: old contents, or merged new lanes in write-through mode.
  always_comb begin
    w_rd_word = r_mem[rd_addr];
    if (RDW_MODE == 1 && wr_en && (wr_addr == rd_addr)) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_mask[l]) w_rd_word[l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
      end
    end
  end

  // Registered read port; data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_run && rd_en) begin
      r_rd_data  <= w_rd_word;
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign init_busy = (r_state == ST_INIT);
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_ram_sdp_init.sv
// Bench for ram_sdp_init: two instances (old-data and write-through
// collision modes) share one stimulus stream and are compared every cycle
// against a behavioural memory model, plus directed literal expectations.
module tb_ram_sdp_init;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;
  localparam int LANE_W = 8;
  localparam int LANES  = WIDTH / LANE_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam logic [WIDTH-1:0] INIT = 16'h0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [LANES-1:0]  wr_mask;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  logic              busy0, busy1, valid0, valid1;
  logic [WIDTH-1:0]  data0, data1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_sdp_init #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LANE_W(LANE_W), .RDW_MODE(0), .INIT_VAL(INIT)) dut0 (
    .clk(clk), .rst_n(rst_n), .init_busy(busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data0), .rd_valid(valid0)
  );

  ram_sdp_init #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LANE_W(LANE_W), .RDW_MODE(1), .INIT_VAL(INIT)) dut1 (
    .clk(clk), .rst_n(rst_n), .init_busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data1), .rd_valid(valid1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_init_left = 0;
  logic             m_known = 1'b0;
  logic             m_valid;
  logic [WIDTH-1:0] m_data0, m_data1;

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                              input logic [WIDTH-1:0] new_w,
                                              input logic [LANES-1:0] mask);
    logic [WIDTH-1:0] bits;
    for (int b = 0; b < WIDTH; b++) bits[b] = mask[b / LANE_W];
    return (new_w & bits) | (old_w & ~bits);
  endfunction

  always @(posedge clk) begin
    logic [WIDTH-1:0] old_w, merged;
    if (!rst_n) begin
      m_init_left = DEPTH;
      m_valid     = 1'b0;
      m_data0     = '0;
      m_data1     = '0;
      m_known     = 1'b1;
    end else if (m_init_left > 0) begin
      m_mem[DEPTH - m_init_left] = INIT;
      m_init_left--;
      m_valid = 1'b0;
    end else begin
      old_w  = m_mem[rd_addr];
      merged = merge(m_mem[wr_addr], wr_data, wr_mask);
      m_valid = rd_en;
      if (rd_en) begin
        m_data0 = old_w;
        m_data1 = (wr_en && wr_addr == rd_addr) ? merged : old_w;
      end
      if (wr_en) m_mem[wr_addr] = merged;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      check("dut0.init_busy", 32'(busy0), 32'(m_init_left > 0));
      check("dut1.init_busy", 32'(busy1), 32'(m_init_left > 0));
      check("dut0.rd_valid", 32'(valid0), 32'(m_valid));
      check("dut1.rd_valid", 32'(valid1), 32'(m_valid));
      check("dut0.rd_data", 32'(data0), 32'(m_data0));
      check("dut1.rd_data", 32'(data1), 32'(m_data1));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drive one cycle of inputs just after a negedge, then wait for the next
  // negedge so the edge in between has taken effect.
  task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                      input logic [LANES-1:0] wm, input logic re, input logic [ADDR_W-1:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm; rd_en = re; rd_addr = ra;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic read_expect(input string name, input logic [ADDR_W-1:0] a,
                             input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1);
    step(1'b0, '0, '0, '0, 1'b1, a);
    check({name, ".d0"}, 32'(data0), 32'(e0));
    check({name, ".d1"}, 32'(data1), 32'(e1));
    check({name, ".v"}, 32'(valid0 & valid1), 32'd1);
  endtask

  // Count negedges after release until busy drops, with inputs held as given.
  task automatic measure_init(input string name, input logic we, input logic re);
    int n;
    n = 0;
    wr_en = we; wr_addr = '0; wr_data = 16'hFFFF; wr_mask = '1; rd_en = re; rd_addr = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (!busy0) break;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    check(name, 32'(n), 32'd16);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (5) @(negedge clk);
    check("reset.busy", 32'(busy0), 32'd1);
    check("reset.valid", 32'(valid0), 32'd0);
    check("reset.data", 32'(data0), 32'd0);

    // Init length and cleared contents.
    measure_init("init_len", 1'b0, 1'b0);
    for (int a = 0; a < DEPTH; a++) read_expect("clear", ADDR_W'(a), 16'h0000, 16'h0000);
    idle();

    // Full write, read, then hold.
    step(1'b1, 4'd3, 16'hA5C3, 2'b11, 1'b0, '0);
    read_expect("wr3", 4'd3, 16'hA5C3, 16'hA5C3);
    idle();
    check("hold.valid", 32'(valid0), 32'd0);
    check("hold.data", 32'(data0), 32'h0000A5C3);

    // Lane mask and empty mask.
    step(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, '0);
    read_expect("mask01", 4'd3, 16'hA534, 16'hA534);
    step(1'b1, 4'd3, 16'hFFFF, 2'b00, 1'b0, '0);
    read_expect("mask00", 4'd3, 16'hA534, 16'hA534);

    // Same-address collision: old data vs write-through.
    step(1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, '0);
    step(1'b1, 4'd5, 16'h2222, 2'b11, 1'b1, 4'd5);
    check("rdw.mode0", 32'(data0), 32'h00001111);
    check("rdw.mode1", 32'(data1), 32'h00002222);
    read_expect("rdw.after", 4'd5, 16'h2222, 16'h2222);
    // Partial-mask collision merges lanes in write-through mode.
    step(1'b1, 4'd5, 16'h99AB, 2'b10, 1'b1, 4'd5);
    check("rdw.part0", 32'(data0), 32'h00002222);
    check("rdw.part1", 32'(data1), 32'h00009922);

    // Reset in RUN, re-reset mid-INIT, port traffic ignored during INIT.
    step(1'b1, 4'd7, 16'hBEEF, 2'b11, 1'b0, '0);
    read_expect("wr7", 4'd7, 16'hBEEF, 16'hBEEF);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'd0, 16'hFFFF, 2'b11, 1'b1, 4'd0);
      check("init.novalid", 32'(valid0 | valid1), 32'd0);
    end
    rst_n = 1'b0;
    idle();
    measure_init("reinit_len", 1'b1, 1'b1);
    read_expect("reinit7", 4'd7, 16'h0000, 16'h0000);
    read_expect("reinit0", 4'd0, 16'h0000, 16'h0000);

    // Seeded pseudo-random traffic; narrow address range forces collisions.
    void'($urandom(100));
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom), ADDR_W'($urandom_range(0, 3)), WIDTH'($urandom), LANES'($urandom),
           1'($urandom), ADDR_W'($urandom_range(0, 3)));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
